// File: rtl/leak_thermal_scaler_if.sv
// Bus bundle for leak_thermal_scaler: sweep request, calibration inputs,
// base-table write port and per-sweep results.
interface leak_thermal_scaler_if #(
  parameter int N_DOMAINS = 4,
  parameter int TEMP_W    = 8
);
  logic                        start;
  logic [N_DOMAINS*TEMP_W-1:0] temp_bus;
  logic [N_DOMAINS*3-1:0]      code_bus;
  logic [7:0]                  leak_ref_temp_c;
  logic [15:0]                 leak_alpha_milli;
  logic [15:0]                 leak_beta_milli;
  logic                        tbl_wr_en;
  logic [2:0]                  tbl_wr_code;
  logic [15:0]                 tbl_wr_data;
  logic [N_DOMAINS*16-1:0]     leak_mw_bus;
  logic [19:0]                 total_leak_mw;
  logic                        busy;
  logic                        done;
  logic                        sat_flag;
  logic                        wr_reject;

  modport master (
    output start, temp_bus, code_bus, leak_ref_temp_c, leak_alpha_milli,
           leak_beta_milli, tbl_wr_en, tbl_wr_code, tbl_wr_data,
    input  leak_mw_bus, total_leak_mw, busy, done, sat_flag, wr_reject
  );

  modport slave (
    input  start, temp_bus, code_bus, leak_ref_temp_c, leak_alpha_milli,
           leak_beta_milli, tbl_wr_en, tbl_wr_code, tbl_wr_data,
    output leak_mw_bus, total_leak_mw, busy, done, sat_flag, wr_reject
  );
endinterface

// File: rtl/leak_thermal_scaler.sv
// Thermal leakage scaler: applies a linear+quadratic temperature factor to a
// DVFS-indexed base-leakage table, one domain at a time, and totals the result.
module leak_thermal_scaler #(
  parameter int N_DOMAINS = 4,
  parameter int TEMP_W    = 8
) (
  input  logic                 clk,
  input  logic                 reset_n,
  leak_thermal_scaler_if.slave bus
);

  localparam int               IDX_W    = (N_DOMAINS > 1) ? $clog2(N_DOMAINS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_DOMAINS - 1);
  localparam logic [15:0]      TBL_INIT [8] = '{16'd120, 16'd140, 16'd165, 16'd190,
                                                16'd215, 16'd240, 16'd260, 16'd260};

  typedef enum logic [2:0] {IDLE, FACTOR, SCALE, ACCUM, FINISH} state_t;

  state_t                      state_reg;
  logic [IDX_W-1:0]            idx_reg;
  logic [15:0]                 tbl_reg  [8];
  logic [15:0]                 snap_reg [8];
  logic [N_DOMAINS*TEMP_W-1:0] temp_reg;
  logic [N_DOMAINS*3-1:0]      code_reg;
  logic [7:0]                  ref_reg;
  logic [15:0]                 alpha_reg;
  logic [15:0]                 beta_reg;
  logic signed [63:0]          factor_reg;
  logic [15:0]                 scaled_reg;
  logic [19:0]                 sum_reg;
  logic                        sat_run_reg;
  logic [15:0]                 leak_reg [N_DOMAINS];
  logic [19:0]                 total_reg;
  logic                        busy_reg;
  logic                        done_reg;
  logic                        sat_reg;
  logic                        wr_reject_reg;

  logic [TEMP_W-1:0]           temp_arr [N_DOMAINS];
  logic [2:0]                  code_arr [N_DOMAINS];

  genvar gi;
  generate
    for (gi = 0; gi < N_DOMAINS; gi++) begin : g_dom
      assign temp_arr[gi]                 = temp_reg[gi*TEMP_W +: TEMP_W];
      assign code_arr[gi]                 = code_reg[gi*3 +: 3];
      assign bus.leak_mw_bus[gi*16 +: 16] = leak_reg[gi];
    end
  endgenerate

  assign bus.total_leak_mw = total_reg;
  assign bus.busy          = busy_reg;
  assign bus.done          = done_reg;
  assign bus.sat_flag      = sat_reg;
  assign bus.wr_reject     = wr_reject_reg;

  logic signed [63:0] delta;
  logic signed [63:0] factor_next;
  logic signed [63:0] prod;
  logic signed [63:0] raw;
  logic [15:0]        base;
  logic [15:0]        clamp_next;
  logic               clamp_sat;

  // 64-bit signed datapath keeps beta*delta^2 and base*factor exact for wide TEMP_W.
  always_comb begin
    delta       = $signed(64'(temp_arr[idx_reg])) - $signed(64'(ref_reg));
    factor_next = 64'sd1000 + $signed(64'(alpha_reg)) * delta
                + ($signed(64'(beta_reg)) * delta * delta) / 64'sd1000;
    base        = snap_reg[code_arr[idx_reg]];
    prod        = $signed(64'(base)) * factor_reg;
    raw         = (factor_reg > 64'sd0) ? prod / 64'sd1000 : 64'sd0;
    clamp_next  = raw[15:0];
    clamp_sat   = 1'b0;
    if (raw < 64'sd1) begin
      clamp_next = 16'd1;
      clamp_sat  = 1'b1;
    end else if (raw > 64'sd65535) begin
      clamp_next = 16'hFFFF;
      clamp_sat  = 1'b1;
    end
  end

  // Writes land only while idle; the sweep reads its own snapshot taken at start.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 8; i++) tbl_reg[i] <= TBL_INIT[i];
    end else if (bus.tbl_wr_en && state_reg == IDLE) begin
      tbl_reg[bus.tbl_wr_code] <= bus.tbl_wr_data;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg     <= IDLE;
      idx_reg       <= '0;
      temp_reg      <= '0;
      code_reg      <= '0;
      ref_reg       <= '0;
      alpha_reg     <= '0;
      beta_reg      <= '0;
      factor_reg    <= '0;
      scaled_reg    <= '0;
      sum_reg       <= '0;
      sat_run_reg   <= 1'b0;
      total_reg     <= '0;
      busy_reg      <= 1'b0;
      done_reg      <= 1'b0;
      sat_reg       <= 1'b0;
      wr_reject_reg <= 1'b0;
      for (int i = 0; i < 8; i++) snap_reg[i] <= '0;
      for (int i = 0; i < N_DOMAINS; i++) leak_reg[i] <= '0;
    end else begin
      done_reg      <= 1'b0;
      wr_reject_reg <= bus.tbl_wr_en && (state_reg != IDLE);
      case (state_reg)
        IDLE: begin
          if (bus.start) begin
            temp_reg    <= bus.temp_bus;
            code_reg    <= bus.code_bus;
            ref_reg     <= bus.leak_ref_temp_c;
            alpha_reg   <= bus.leak_alpha_milli;
            beta_reg    <= bus.leak_beta_milli;
            snap_reg    <= tbl_reg;
            sum_reg     <= '0;
            sat_run_reg <= 1'b0;
            idx_reg     <= '0;
            busy_reg    <= 1'b1;
            state_reg   <= FACTOR;
          end
        end
        FACTOR: begin
          factor_reg <= factor_next;
          state_reg  <= SCALE;
        end
        SCALE: begin
          scaled_reg  <= clamp_next;
          sat_run_reg <= sat_run_reg | clamp_sat;
          state_reg   <= ACCUM;
        end
        ACCUM: begin
          leak_reg[idx_reg] <= scaled_reg;
          sum_reg           <= sum_reg + 20'(scaled_reg);
          if (idx_reg == LAST_IDX) begin
            total_reg <= sum_reg + 20'(scaled_reg);
            sat_reg   <= sat_run_reg;
            done_reg  <= 1'b1;
            state_reg <= FINISH;
          end else begin
            idx_reg   <= idx_reg + IDX_W'(1);
            state_reg <= FACTOR;
          end
        end
        FINISH: begin
          busy_reg  <= 1'b0;
          state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_leak_thermal_scaler.sv
// Self-checking bench for leak_thermal_scaler: vector table of sweeps with a
// result scoreboard, plus table-write, busy-protection and mid-sweep reset sequences.
`timescale 1ns/1ps
module tb_leak_thermal_scaler;
  localparam int N  = 4;
  localparam int TW = 8;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  leak_thermal_scaler_if #(.N_DOMAINS(N), .TEMP_W(TW)) bus ();
  leak_thermal_scaler #(.N_DOMAINS(N), .TEMP_W(TW)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  typedef struct packed {
    logic [63:0] leak;
    logic [19:0] total;
    logic        sat;
  } res_t;

  typedef struct packed {
    logic [31:0] temps;
    logic [11:0] codes;
    logic [7:0]  ref_c;
    logic [15:0] alpha;
    logic [15:0] beta;
    res_t        res;
  } vec_t;

  res_t        sb[$];
  vec_t        vecs[6];
  vec_t        hi_vec;
  vec_t        big_vec;
  int          n_cmp = 0;
  int          n_err = 0;
  int          done_cnt = 0;
  int          base_cnt;
  logic [63:0] prev_bus;
  logic [19:0] prev_total;

  always @(negedge clk) if (bus.done === 1'b1) done_cnt++;

  initial begin
    #1ms;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  function automatic vec_t mk(input logic [31:0] t, input logic [11:0] c, input logic [7:0] r,
                              input logic [15:0] a, input logic [15:0] b,
                              input logic [63:0] l, input logic [19:0] tot, input logic s);
    vec_t v;
    v.temps = t; v.codes = c; v.ref_c = r; v.alpha = a; v.beta = b;
    v.res.leak = l; v.res.total = tot; v.res.sat = s;
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, expv);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"}, 64'(bus.busy), 64'd0);
    check({tag, "_done"}, 64'(bus.done), 64'd0);
    check({tag, "_sat"}, 64'(bus.sat_flag), 64'd0);
    check({tag, "_wr_reject"}, 64'(bus.wr_reject), 64'd0);
    check({tag, "_total"}, 64'(bus.total_leak_mw), 64'd0);
    check({tag, "_leak_bus"}, bus.leak_mw_bus, 64'd0);
  endtask

  task automatic tbl_write(input logic [2:0] code, input logic [15:0] data);
    bus.tbl_wr_en = 1'b1; bus.tbl_wr_code = code; bus.tbl_wr_data = data;
    @(negedge clk);
    bus.tbl_wr_en = 1'b0;
    check("wr_reject_idle", 64'(bus.wr_reject), 64'd0);
  endtask

  // Called at a negedge; inj_cyc pulses start+write mid-sweep, rst_cyc aborts via reset.
  task automatic run_sweep(input vec_t v, input int inj_cyc, input int rst_cyc, input string tag);
    int   cyc;
    bit   seen;
    res_t e;
    bus.temp_bus = v.temps; bus.code_bus = v.codes; bus.leak_ref_temp_c = v.ref_c;
    bus.leak_alpha_milli = v.alpha; bus.leak_beta_milli = v.beta;
    bus.start = 1'b1;
    sb.push_back(v.res);
    @(negedge clk);
    cyc = 1;
    bus.start = 1'b0;
    bus.tbl_wr_en = 1'b0;
    bus.temp_bus = $urandom; bus.code_bus = 12'($urandom); bus.leak_ref_temp_c = 8'($urandom);
    bus.leak_alpha_milli = 16'($urandom); bus.leak_beta_milli = 16'($urandom);
    check({tag, "_busy_rise"}, 64'(bus.busy), 64'd1);
    check({tag, "_hold_leak"}, bus.leak_mw_bus, prev_bus);
    check({tag, "_hold_total"}, 64'(bus.total_leak_mw), 64'(prev_total));
    seen = 1'b0;
    while (!seen && cyc <= 60) begin
      if (cyc == inj_cyc) begin
        bus.start = 1'b1; bus.tbl_wr_en = 1'b1; bus.tbl_wr_code = 3'd3; bus.tbl_wr_data = 16'd5;
      end
      if (inj_cyc > 0 && cyc == inj_cyc + 1) begin
        bus.start = 1'b0; bus.tbl_wr_en = 1'b0;
        check({tag, "_wr_reject_pulse"}, 64'(bus.wr_reject), 64'd1);
      end
      if (inj_cyc > 0 && cyc == inj_cyc + 2)
        check({tag, "_wr_reject_clear"}, 64'(bus.wr_reject), 64'd0);
      if (cyc == rst_cyc) begin
        reset_n = 1'b0;
        #1;
        check_all_zero({tag, "_async_rst"});
        void'(sb.pop_front());
        prev_bus = '0; prev_total = '0;
        repeat (3) begin
          @(negedge clk);
          check({tag, "_rst_no_done"}, 64'(bus.done), 64'd0);
        end
        reset_n = 1'b1;
        @(negedge clk);
        $display("sweep %s: aborted by reset at cycle %0d", tag, cyc);
        return;
      end
      if (bus.done === 1'b1) begin
        seen = 1'b1;
        e = sb.pop_front();
        check({tag, "_done_cycle"}, 64'(cyc), 64'(3 * N + 1));
        for (int d = 0; d < N; d++)
          check($sformatf("%s_leak%0d", tag, d), 64'(bus.leak_mw_bus[d*16 +: 16]), 64'(e.leak[d*16 +: 16]));
        check({tag, "_total"}, 64'(bus.total_leak_mw), 64'(e.total));
        check({tag, "_sat"}, 64'(bus.sat_flag), 64'(e.sat));
        prev_bus = e.leak; prev_total = e.total;
        $display("sweep %s: done at cycle %0d total=%0d sat=%0d", tag, cyc, bus.total_leak_mw, bus.sat_flag);
      end else begin
        @(negedge clk);
        cyc++;
      end
    end
    if (!seen) check({tag, "_done_timeout"}, 64'd0, 64'd1);
    @(negedge clk);
    check({tag, "_done_pulse_width"}, 64'(bus.done), 64'd0);
    check({tag, "_busy_fall"}, 64'(bus.busy), 64'd0);
  endtask

  initial begin
    vecs[0] = mk({8'd90, 8'd70, 8'd50, 8'd20}, {3'd3, 3'd3, 3'd3, 3'd3}, 8'd50, 16'd20, 16'd0,
                 {16'd342, 16'd266, 16'd190, 16'd76}, 20'd874, 1'b0);
    vecs[1] = mk({8'd70, 8'd20, 8'd50, 8'd90}, {3'd3, 3'd3, 3'd3, 3'd3}, 8'd50, 16'd20, 16'd10,
                 {16'd266, 16'd77, 16'd190, 16'd345}, 20'd878, 1'b0);
    vecs[2] = mk({8'd50, 8'd50, 8'd50, 8'd20}, {3'd2, 3'd1, 3'd0, 3'd0}, 8'd50, 16'd50, 16'd0,
                 {16'd165, 16'd140, 16'd120, 16'd1}, 20'd426, 1'b1);
    vecs[3] = mk({8'd255, 8'd100, 8'd0, 8'd25}, {3'd7, 3'd6, 3'd5, 3'd0}, 8'd25, 16'd5, 16'd3,
                 {16'd600, 16'd361, 16'd210, 16'd120}, 20'd1291, 1'b0);
    vecs[4] = mk({8'd1, 8'd10, 8'd0, 8'd255}, {3'd4, 3'd1, 3'd7, 3'd7}, 8'd0, 16'd1000, 16'd0,
                 {16'd430, 16'd1540, 16'd260, 16'd65535}, 20'd67765, 1'b1);
    vecs[5] = mk({8'd60, 8'd50, 8'd100, 8'd0}, {3'd3, 3'd3, 3'd3, 3'd3}, 8'd50, 16'd0, 16'd1000,
                 {16'd209, 16'd190, 16'd665, 16'd665}, 20'd1729, 1'b0);
    hi_vec  = mk({8'd50, 8'd50, 8'd50, 8'd90}, {3'd0, 3'd0, 3'd0, 3'd6}, 8'd50, 16'd20, 16'd0,
                 {16'd120, 16'd120, 16'd120, 16'd65535}, 20'd65895, 1'b1);
    big_vec = mk({8'd90, 8'd70, 8'd50, 8'd20}, {3'd3, 3'd3, 3'd3, 3'd3}, 8'd50, 16'd20, 16'd0,
                 {16'd1800, 16'd1400, 16'd1000, 16'd400}, 20'd4600, 1'b0);

    bus.start = 1'b0; bus.temp_bus = '0; bus.code_bus = '0; bus.leak_ref_temp_c = '0;
    bus.leak_alpha_milli = '0; bus.leak_beta_milli = '0;
    bus.tbl_wr_en = 1'b0; bus.tbl_wr_code = '0; bus.tbl_wr_data = '0;
    prev_bus = '0; prev_total = '0;
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    reset_n = 1'b1;
    @(negedge clk);

    foreach (vecs[i]) run_sweep(vecs[i], 0, 0, $sformatf("vec%0d", i));

    tbl_write(3'd6, 16'hFFFF);
    run_sweep(hi_vec, 0, 0, "clamp_high");
    tbl_write(3'd6, 16'd260);

    bus.tbl_wr_en = 1'b1; bus.tbl_wr_code = 3'd3; bus.tbl_wr_data = 16'd1000;
    run_sweep(vecs[0], 0, 0, "start_with_write");
    run_sweep(big_vec, 0, 0, "after_write");
    tbl_write(3'd3, 16'd190);

    base_cnt = done_cnt;
    run_sweep(vecs[0], 4, 0, "busy_protect");
    repeat (20) @(negedge clk);
    check("busy_single_done", 64'(done_cnt - base_cnt), 64'd1);
    check("busy_idle_after", 64'(bus.busy), 64'd0);
    run_sweep(vecs[0], 0, 0, "after_reject");

    base_cnt = done_cnt;
    run_sweep(vecs[1], 0, 5, "reset_mid");
    check("reset_mid_no_done", 64'(done_cnt - base_cnt), 64'd0);
    run_sweep(vecs[0], 0, 0, "after_reset");

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end
endmodule
